// File: rtl/knn_query_sequencer_pkg.sv
// Shared types and constants for the bitNN per-query sequencer.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
// Contents: seq_state_t phase encoding, default K / NUM_BDU constants, busy decode helper.
package knn_query_sequencer_pkg;

  localparam int KNN_K       = 8;
  localparam int KNN_NUM_BDU = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_NEWQ   = 3'd1,
    ST_SEED   = 3'd2,
    ST_STREAM = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_COMMIT = 3'd5,
    ST_DONE   = 3'd6
  } seq_state_t;

  // A run is in progress in every phase except the two resting ones.
  function automatic logic state_is_busy(input seq_state_t s);
    return (s != ST_IDLE) && (s != ST_DONE);
  endfunction

endpackage

// File: rtl/knn_batch_tracker.sv
// Batch handshake tracker: one memory batch in flight at a time, counts completed batches.
// Latency: batch_req is combinational from state; all_batches_done reflects a bdus_done in the same cycle.
// Backpressure: batch_req is held until batch_gnt; the next request waits for bdus_done of the outstanding batch.
// Ports: clk, reset (sync, active-high); start_query clears the count for a new query;
//   stream_en permits requests; num_batches (latched by the top); batch_gnt / bdus_done from
//   the memory controller / BDU array; batch_req and all_batches_done outputs.
module knn_batch_tracker #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_query,
  input  logic             stream_en,
  input  logic [CNT_W-1:0] num_batches,
  input  logic             batch_gnt,
  input  logic             bdus_done,
  output logic             batch_req,
  output logic             all_batches_done
);

  logic             outstanding_q, outstanding_d;
  logic [CNT_W-1:0] done_cnt_q, done_cnt_d;
  logic             gnt_acc;
  logic             done_acc;

  always_comb begin
    outstanding_d = outstanding_q;
    done_cnt_d    = done_cnt_q;

    // Request only while streaming, with nothing in flight and batches left.
    batch_req = stream_en && !outstanding_q && (done_cnt_q != num_batches);
    // Grants without a pending request and completions with nothing in
    // flight are stray pulses and must not move the count.
    gnt_acc   = batch_req && batch_gnt;
    done_acc  = outstanding_q && bdus_done;

    if (start_query) begin
      outstanding_d = 1'b0;
      done_cnt_d    = '0;
    end else begin
      if (gnt_acc) begin
        outstanding_d = 1'b1;
      end
      if (done_acc) begin
        outstanding_d = 1'b0;
        done_cnt_d    = done_cnt_q + CNT_W'(1);
      end
    end

    // Looks at the next count so the top leaves STREAM in the same cycle
    // the final bdus_done arrives.
    all_batches_done = (done_cnt_d == num_batches);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding_q <= 1'b0;
      done_cnt_q    <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      done_cnt_q    <= done_cnt_d;
    end
  end

endmodule

// File: rtl/knn_query_sequencer.sv
// Per-query scheduler for the bitNN datapath: NEWQ -> SEED (K cycles, skipped for the first query)
//   -> STREAM batches -> DRAIN -> COMMIT, repeated num_queries times, then DONE.
// Latency per query: 1 + (prev_valid ? K : 0) + stream time + DRAIN_CYCLES + 1 cycles.
// Backpressure: STREAM waits on batch_gnt / bdus_done; start is ignored while busy.
// Ports: clk, reset (sync, active-high); start/num_queries/num_batches launch a run;
//   batch_req/batch_gnt/bdus_done talk to memory + BDU array; new_query, query_idx, seed_idx,
//   topK_input_sel, topK_inputs_valid_sel, topK_done steer topK; busy/done report run status.
// Optional: KNN_SEQ_PERF_CNT_EN adds saturating perf_stall_cycles / perf_total_cycles outputs.
module knn_query_sequencer
  import knn_query_sequencer_pkg::*;
#(
  parameter int  K            = KNN_K,
  parameter int  CNT_W        = 16,
  parameter int  DRAIN_CYCLES = 4,
  localparam int SEED_W       = (K > 1) ? $clog2(K) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_queries,
  input  logic [CNT_W-1:0]  num_batches,
  output logic              batch_req,
  input  logic              batch_gnt,
  input  logic              bdus_done,
  output logic              new_query,
  output logic [CNT_W-1:0]  query_idx,
  output logic [SEED_W-1:0] seed_idx,
  output logic              topK_input_sel,
  output logic              topK_inputs_valid_sel,
  output logic              topK_done,
  output logic              busy,
  output logic              done
`ifdef KNN_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall_cycles,
  output logic [31:0]       perf_total_cycles
`endif
);

  localparam int                DRAIN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [SEED_W-1:0]  SEED_LAST  = SEED_W'(K - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W:0]     ONE_EXT    = 1;

  seq_state_t         state_q, state_d;
  logic [CNT_W-1:0]   nq_q, nq_d;
  logic [CNT_W-1:0]   nb_q, nb_d;
  logic [CNT_W-1:0]   query_idx_q, query_idx_d;
  logic               prev_valid_q, prev_valid_d;
  logic [SEED_W-1:0]  seed_cnt_q, seed_cnt_d;
  logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;

  logic start_query;
  logic stream_en;
  logic all_batches_done;
  logic start_acc;

  knn_batch_tracker #(
    .CNT_W (CNT_W)
  ) u_tracker (
    .clk              (clk),
    .reset            (reset),
    .start_query      (start_query),
    .stream_en        (stream_en),
    .num_batches      (nb_q),
    .batch_gnt        (batch_gnt),
    .bdus_done        (bdus_done),
    .batch_req        (batch_req),
    .all_batches_done (all_batches_done)
  );

  always_comb begin
    state_d               = state_q;
    nq_d                  = nq_q;
    nb_d                  = nb_q;
    query_idx_d           = query_idx_q;
    prev_valid_d          = prev_valid_q;
    seed_cnt_d            = '0;
    drain_cnt_d           = '0;
    start_query           = 1'b0;
    stream_en             = 1'b0;
    start_acc             = 1'b0;
    new_query             = 1'b0;
    topK_input_sel        = 1'b1;
    topK_inputs_valid_sel = 1'b0;
    topK_done             = 1'b0;
    done                  = 1'b0;
    busy                  = state_is_busy(state_q);

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        done = (state_q == ST_DONE);
        if (start) begin
          start_acc    = 1'b1;
          nq_d         = num_queries;
          nb_d         = num_batches;
          query_idx_d  = '0;
          prev_valid_d = 1'b0;
          state_d      = (num_queries == '0) ? ST_DONE : ST_NEWQ;
        end
      end

      ST_NEWQ: begin
        new_query   = 1'b1;
        start_query = 1'b1;
        // The first query of a run has no cached neighbours to seed with.
        if (prev_valid_q) begin
          state_d = ST_SEED;
        end else begin
          state_d = (nb_q == '0) ? ST_DRAIN : ST_STREAM;
        end
      end

      ST_SEED: begin
        topK_input_sel        = 1'b0;
        topK_inputs_valid_sel = 1'b1;
        if (seed_cnt_q == SEED_LAST) begin
          state_d = (nb_q == '0) ? ST_DRAIN : ST_STREAM;
        end else begin
          seed_cnt_d = seed_cnt_q + SEED_W'(1);
        end
      end

      ST_STREAM: begin
        stream_en = 1'b1;
        if (all_batches_done) begin
          state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d = ST_COMMIT;
        end else begin
          drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
        end
      end

      ST_COMMIT: begin
        topK_done    = 1'b1;
        prev_valid_d = 1'b1;
        // Compared one bit wider so query_idx never wraps.
        if (({1'b0, query_idx_q} + ONE_EXT) == {1'b0, nq_q}) begin
          state_d = ST_DONE;
        end else begin
          query_idx_d = query_idx_q + CNT_W'(1);
          state_d     = ST_NEWQ;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign query_idx = query_idx_q;
  assign seed_idx  = seed_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      nq_q         <= '0;
      nb_q         <= '0;
      query_idx_q  <= '0;
      prev_valid_q <= 1'b0;
      seed_cnt_q   <= '0;
      drain_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      nq_q         <= nq_d;
      nb_q         <= nb_d;
      query_idx_q  <= query_idx_d;
      prev_valid_q <= prev_valid_d;
      seed_cnt_q   <= seed_cnt_d;
      drain_cnt_q  <= drain_cnt_d;
    end
  end

`ifdef KNN_SEQ_PERF_CNT_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] total_q, total_d;

  always_comb begin
    stall_d = stall_q;
    total_d = total_q;
    if (start_acc) begin
      stall_d = '0;
      total_d = '0;
    end else begin
      if ((state_q == ST_STREAM) && batch_req && !batch_gnt && (stall_q != '1)) begin
        stall_d = stall_q + 32'd1;
      end
      if (busy && (total_q != '1)) begin
        total_d = total_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      total_q <= '0;
    end else begin
      stall_q <= stall_d;
      total_q <= total_d;
    end
  end

  assign perf_stall_cycles = stall_q;
  assign perf_total_cycles = total_q;
`endif

endmodule

// File: tb/tb_knn_query_sequencer.sv
// Self-checking bench for knn_query_sequencer.
// The reference is a timeline model: for each query it derives when new_query, the seed
// window, batch requests and topK_done must occur from the phase-length rules, while a
// reactive memory/BDU model drives batch_gnt / bdus_done with fixed or random delays.
`timescale 1ns/1ps
module tb_knn_query_sequencer;

  localparam int K     = 8;
  localparam int CNT_W = 16;
  localparam int DRAIN = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [CNT_W-1:0] num_queries;
  logic [CNT_W-1:0] num_batches;
  logic             batch_req;
  logic             batch_gnt;
  logic             bdus_done;
  logic             new_query;
  logic [CNT_W-1:0] query_idx;
  logic [2:0]       seed_idx;
  logic             topK_input_sel;
  logic             topK_inputs_valid_sel;
  logic             topK_done;
  logic             busy;
  logic             done;
`ifdef KNN_SEQ_PERF_CNT_EN
  logic [31:0]      perf_stall_cycles;
  logic [31:0]      perf_total_cycles;
`endif

  int checks = 0;
  int errors = 0;
  int m_stall;
  int m_busy;

  always #5 clk = ~clk;

  knn_query_sequencer #(
    .K            (K),
    .CNT_W        (CNT_W),
    .DRAIN_CYCLES (DRAIN)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .start                 (start),
    .num_queries           (num_queries),
    .num_batches           (num_batches),
    .batch_req             (batch_req),
    .batch_gnt             (batch_gnt),
    .bdus_done             (bdus_done),
    .new_query             (new_query),
    .query_idx             (query_idx),
    .seed_idx              (seed_idx),
    .topK_input_sel        (topK_input_sel),
    .topK_inputs_valid_sel (topK_inputs_valid_sel),
    .topK_done             (topK_done),
    .busy                  (busy),
    .done                  (done)
`ifdef KNN_SEQ_PERF_CNT_EN
    ,
    .perf_stall_cycles     (perf_stall_cycles),
    .perf_total_cycles     (perf_total_cycles)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_batch_req"}, batch_req, 0);
    chk({tag, "_new_query"}, new_query, 0);
    chk({tag, "_query_idx"}, query_idx, 0);
    chk({tag, "_seed_idx"}, seed_idx, 0);
    chk({tag, "_input_sel"}, topK_input_sel, 1);
    chk({tag, "_valid_sel"}, topK_inputs_valid_sel, 0);
    chk({tag, "_topK_done"}, topK_done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // gfix/dfix < 0 pick random grant (0..3) / completion (1..4) delays per batch.
  // spur adds stray grants, completions and start pulses the DUT must ignore.
  // abort_at >= 0 asserts reset during that cycle of the run.
  task automatic run(input int nq, input int nb, input int gfix, input int dfix,
                     input bit spur, input int abort_at);
    int  q, t_newq, next_newq, stream_start, exp_commit, req_from, finished;
    int  gw, dw, end_cyc, tk_seen, gnt_seen, s_len;
    bit  outst, run_over, req_e, in_seed, aborted, ended;

    @(negedge clk);
    num_queries = 16'(nq);
    num_batches = 16'(nb);
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    // Counts are only sampled at start; scramble them afterwards.
    num_queries = 16'($urandom);
    num_batches = 16'($urandom);

    m_stall = 0; m_busy = 0; tk_seen = 0; gnt_seen = 0;
    aborted = 0; ended = 0; outst = 0; finished = 0; gw = 0; dw = 0;
    q = 0; t_newq = -100; stream_start = 0; req_from = 1 << 30;
    exp_commit = -1; next_newq = 0;
    run_over = (nq == 0);
    end_cyc  = run_over ? 2 : -1;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (!run_over && cyc == next_newq) begin
        t_newq       = cyc;
        s_len        = (q > 0) ? K : 0;
        stream_start = cyc + 1 + s_len;
        exp_commit   = (nb == 0) ? stream_start + DRAIN : -1;
        req_from     = stream_start;
        finished     = 0;
        outst        = 0;
        gw           = (gfix < 0) ? int'($urandom_range(0, 3)) : gfix;
      end
      in_seed = !run_over && (q > 0) && (cyc > t_newq) && (cyc <= t_newq + K);
      req_e   = !run_over && (nb > 0) && (cyc >= req_from) && !outst && (finished < nb);

      chk("new_query", new_query, 32'(!run_over && cyc == t_newq));
      chk("topK_done", topK_done, 32'(!run_over && cyc == exp_commit));
      chk("busy", busy, 32'(!run_over));
      chk("done", done, 32'(run_over));
      chk("valid_sel", topK_inputs_valid_sel, 32'(in_seed));
      chk("input_sel", topK_input_sel, 32'(!in_seed));
      chk("batch_req", batch_req, 32'(req_e));
      if (in_seed) chk("seed_idx", seed_idx, 32'(cyc - t_newq - 1));
      if (!run_over) chk("query_idx", query_idx, 32'(q));
      if (topK_done === 1'b1) tk_seen++;

      // Drive this cycle's memory-controller / BDU inputs.
      batch_gnt = 1'b0;
      bdus_done = 1'b0;
      start     = 1'b0;
      if (outst) begin
        dw--;
        if (dw == 0) begin
          bdus_done = 1'b1;
          outst     = 0;
          finished++;
          req_from  = cyc + 1;
          if (finished == nb) exp_commit = cyc + DRAIN + 1;
        end
      end else if (req_e) begin
        if (gw == 0) begin
          batch_gnt = 1'b1;
          outst     = 1;
          dw        = (dfix < 0) ? int'($urandom_range(1, 4)) : dfix;
          gw        = (gfix < 0) ? int'($urandom_range(0, 3)) : gfix;
        end else begin
          gw--;
          m_stall++;
        end
      end else if (spur) begin
        batch_gnt = ($urandom_range(0, 3) == 0);
        bdus_done = ($urandom_range(0, 3) == 0);
      end
      if (spur && !run_over && $urandom_range(0, 7) == 0) start = 1'b1;
      if (batch_gnt && batch_req === 1'b1) gnt_seen++;
      if (!run_over) m_busy++;

      if (!run_over && cyc == exp_commit) begin
        if (q + 1 == nq) begin
          run_over = 1;
          end_cyc  = cyc + 3;
        end else begin
          q++;
          next_newq = cyc + 1;
        end
      end

      if (abort_at >= 0 && cyc == abort_at) begin
        reset     = 1'b1;
        batch_gnt = 1'b0;
        bdus_done = 1'b0;
        start     = 1'b0;
        aborted   = 1;
      end

      @(negedge clk);
      if (aborted) begin
        chk_reset("abort");
        reset = 1'b0;
        ended = 1;
        break;
      end
      if (run_over && cyc >= end_cyc) begin
        ended = 1;
        break;
      end
    end
    batch_gnt = 1'b0;
    bdus_done = 1'b0;
    start     = 1'b0;

    chk("run_terminated", 32'(ended), 1);
    if (aborted) begin
      chk("abort_no_topK_done", tk_seen, 0);
`ifdef KNN_SEQ_PERF_CNT_EN
      chk("abort_perf_stall", perf_stall_cycles, 0);
      chk("abort_perf_total", perf_total_cycles, 0);
`endif
    end else begin
      chk("topK_done_count", tk_seen, 32'(nq));
      chk("grant_count", gnt_seen, 32'(nq * nb));
`ifdef KNN_SEQ_PERF_CNT_EN
      chk("perf_stall", perf_stall_cycles, 32'(m_stall));
      chk("perf_total", perf_total_cycles, 32'(m_busy));
`endif
    end
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    num_queries = '0;
    num_batches = '0;
    batch_gnt   = 1'b0;
    bdus_done   = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    reset = 1'b0;
    @(negedge clk);
    chk_reset("idle");

    // One query, two batches: grant 1 cycle after request, completion 5 after grant.
    run(1, 2, 1, 5, 0, -1);
    // Three queries: queries 1 and 2 are seeded from the cache.
    run(3, 1, -1, -1, 0, -1);
    // Grant withheld for 10 cycles.
    run(1, 1, 10, 3, 0, -1);
`ifdef KNN_SEQ_PERF_CNT_EN
    chk("perf_stall_10", perf_stall_cycles, 10);
`endif
    // Stray grants / completions / starts.
    run(2, 3, -1, -1, 1, -1);
    // Empty run, then zero batches per query.
    run(0, 2, -1, -1, 0, -1);
    run(2, 0, -1, -1, 1, -1);
    // Reset during STREAM, then a clean restart.
    run(2, 3, 2, 4, 0, 9);
    run(2, 2, -1, -1, 0, -1);
    for (int i = 0; i < 4; i++) begin
      run(int'($urandom_range(1, 3)), int'($urandom_range(0, 3)), -1, -1, 1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
